// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock with a
// bounded number of retries, then releases the downstream system reset.
// Every output is decoded from registered state, so none follows an input
// combinationally.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 256,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  // The counter is sized for the longest timed state. Each state leaves on
  // its terminal count, so the counter never wraps while in a state.
  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                          RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             locked_meta, locked_s;

  // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
  // NOTE: sequential state is always written with non-blocking (<=) so that
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  // State, shared cycle counter and the two event counters.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
    end
  end

  // Next-state, counter and retry/loss bookkeeping.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    retry_nxt = retry_count;
    loss_nxt  = lock_loss_count;

    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = RESET_PLL;
            retry_nxt = retry_count + 4'd1;
          end
        end
      end

      STABILIZE: begin
        // A single unlocked cycle restarts the wait without costing a retry.
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end

      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt = RESET_PLL;
          if (lock_loss_count != 8'hFF) loss_nxt = lock_loss_count + 8'd1;
        end
      end

      FAULT: begin
        cnt_nxt = '0;
        if (clear_fault) begin
          state_nxt = RESET_PLL;
          retry_nxt = '0;
        end
      end

      default: begin
        state_nxt = RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase

    // Every state starts timing from zero.
    if (state_nxt != state) cnt_nxt = '0;
  end

  assign pll_rst = (state == RESET_PLL) || (state == FAULT);
  assign sys_rst = (state != RUN);
  assign ready   = (state == RUN);
  assign fault   = (state == FAULT);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed vector table, hand-written
// corner sequences and a randomized run, all against a behavioural model.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       clear_fault;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .STABLE_CYCLES      (ST),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .locked         (locked),
    .clear_fault    (clear_fault),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  // Phases with "cycles spent so far"; lock flag seen through a 2-deep delay.
  typedef enum int {PH_RST, PH_WAIT, PH_STAB, PH_RUN, PH_FAULT} phase_t;

  phase_t m_phase;
  int     m_spent;
  int     m_retries;
  int     m_losses;
  bit     m_dl[$];

  function automatic logic [15:0] pk(bit p, bit s, bit r, bit f, int rc, int lc);
    return {p, s, r, f, rc[3:0], lc[7:0]};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count};
  endfunction

  function automatic logic [15:0] model_vec();
    bit run_ph;
    bit flt_ph;
    run_ph = (m_phase == PH_RUN);
    flt_ph = (m_phase == PH_FAULT);
    return pk((m_phase == PH_RST) || flt_ph, !run_ph, run_ph, flt_ph,
              m_retries, m_losses);
  endfunction

  task automatic model_reset();
    m_phase   = PH_RST;
    m_spent   = 0;
    m_retries = 0;
    m_losses  = 0;
    m_dl.delete();
    m_dl.push_back(1'b0);
    m_dl.push_back(1'b0);
  endtask

  task automatic model_go(phase_t p);
    m_phase = p;
    m_spent = 0;
  endtask

  task automatic model_edge(bit l, bit c);
    bit ls;
    ls = m_dl.pop_front();
    m_dl.push_back(l);
    m_spent++;
    case (m_phase)
      PH_RST:   if (m_spent == RP) model_go(PH_WAIT);
      PH_WAIT: begin
        if (ls) model_go(PH_STAB);
        else if (m_spent == TO) begin
          if (m_retries == MR) model_go(PH_FAULT);
          else begin
            m_retries++;
            model_go(PH_RST);
          end
        end
      end
      PH_STAB: begin
        if (!ls) model_go(PH_WAIT);
        else if (m_spent == ST) begin
          m_retries = 0;
          model_go(PH_RUN);
        end
      end
      PH_RUN: begin
        if (!ls) begin
          if (m_losses < 255) m_losses++;
          model_go(PH_RST);
        end
      end
      PH_FAULT: begin
        if (c) begin
          m_retries = 0;
          model_go(PH_RST);
        end
      end
      default: model_go(PH_RST);
    endcase
  endtask

  // ---------------- checking and stimulus helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {pll,sys,rdy,flt,retry,loss}=%h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: drive, clock once, compare at the next falling edge.
  task automatic tick(input bit l, input bit c);
    locked      = l;
    clear_fault = c;
    @(posedge refclk);
    model_edge(l, c);
    cyc++;
    @(negedge refclk);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic run(input int n, input bit l, input bit c);
    for (int i = 0; i < n; i++) tick(l, c);
  endtask

  // Asserts rst between edges and checks outputs before the next edge.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check({tag, "_async"}, dut_vec(), pk(1, 1, 0, 0, 0, 0));
    @(negedge refclk);
    check({tag, "_held"}, dut_vec(), pk(1, 1, 0, 0, 0, 0));
    rst = 1'b0;
  endtask

  typedef struct {
    int          cycles;
    bit          lk;
    bit          cf;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, bit l, bit c, logic [15:0] e);
    vec_t v;
    v.cycles = n;
    v.lk     = l;
    v.cf     = c;
    v.exp    = e;
    return v;
  endfunction

  initial begin
    int  len;
    bit  val;

    // Normal lock, RUN with ignored clear, lock loss, three timeouts, fault, clear.
    tbl.push_back(mk( 3, 0, 0, pk(1, 1, 0, 0, 0, 0)));
    tbl.push_back(mk( 1, 0, 0, pk(0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk( 4, 0, 0, pk(0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk(10, 1, 0, pk(0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk( 1, 1, 0, pk(0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk( 3, 1, 1, pk(0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk( 2, 0, 0, pk(0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk( 1, 0, 0, pk(1, 1, 0, 0, 0, 1)));
    tbl.push_back(mk( 3, 0, 0, pk(1, 1, 0, 0, 0, 1)));
    tbl.push_back(mk( 1, 0, 0, pk(0, 1, 0, 0, 0, 1)));
    tbl.push_back(mk( 5, 0, 1, pk(0, 1, 0, 0, 0, 1)));
    tbl.push_back(mk(14, 0, 0, pk(0, 1, 0, 0, 0, 1)));
    tbl.push_back(mk( 1, 0, 0, pk(1, 1, 0, 0, 1, 1)));
    tbl.push_back(mk( 3, 0, 0, pk(1, 1, 0, 0, 1, 1)));
    tbl.push_back(mk( 1, 0, 0, pk(0, 1, 0, 0, 1, 1)));
    tbl.push_back(mk(19, 0, 0, pk(0, 1, 0, 0, 1, 1)));
    tbl.push_back(mk( 1, 0, 0, pk(1, 1, 0, 0, 2, 1)));
    tbl.push_back(mk( 3, 0, 0, pk(1, 1, 0, 0, 2, 1)));
    tbl.push_back(mk( 1, 0, 0, pk(0, 1, 0, 0, 2, 1)));
    tbl.push_back(mk(19, 0, 0, pk(0, 1, 0, 0, 2, 1)));
    tbl.push_back(mk( 1, 0, 0, pk(1, 1, 0, 1, 2, 1)));
    tbl.push_back(mk( 5, 0, 0, pk(1, 1, 0, 1, 2, 1)));
    tbl.push_back(mk( 1, 0, 1, pk(1, 1, 0, 0, 0, 1)));
    tbl.push_back(mk( 1, 0, 1, pk(1, 1, 0, 0, 0, 1)));

    rst         = 1'b1;
    locked      = 1'b0;
    clear_fault = 1'b0;
    model_reset();
    @(negedge refclk);
    check("reset_state", dut_vec(), pk(1, 1, 0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].cycles, tbl[i].lk, tbl[i].cf);
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // STABILIZE glitch after one timeout: retry kept, release delayed.
    apply_reset("pre_glitch");
    run(24, 0, 0);
    check("glitch_retry1", dut_vec(), pk(1, 1, 0, 0, 1, 0));
    run(4, 0, 0);
    check("glitch_wait", dut_vec(), pk(0, 1, 0, 0, 1, 0));
    run(6, 1, 0);
    check("glitch_stab", dut_vec(), pk(0, 1, 0, 0, 1, 0));
    run(1, 0, 0);
    run(2, 1, 0);
    check("glitch_back_wait", dut_vec(), pk(0, 1, 0, 0, 1, 0));
    run(8, 1, 0);
    check("glitch_delayed", dut_vec(), pk(0, 1, 0, 0, 1, 0));
    run(1, 1, 0);
    check("glitch_release", dut_vec(), pk(0, 0, 1, 0, 0, 0));

    // Async reset mid-RUN, then mid-STABILIZE.
    run(2, 1, 1);
    check("run_clear_ignored", dut_vec(), pk(0, 0, 1, 0, 0, 0));
    apply_reset("mid_run");
    run(6, 1, 0);
    check("mid_stab_pre", dut_vec(), pk(0, 1, 0, 0, 0, 0));
    apply_reset("mid_stab");

    // 300 lock losses: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      run(13, 1, 0);
      run(3, 0, 0);
      if (i == 0) check("loss_first", dut_vec(), pk(1, 1, 0, 0, 0, 1));
      if (i == 254) check("loss_255", dut_vec(), pk(1, 1, 0, 0, 0, 255));
    end
    check("loss_saturated", dut_vec(), pk(1, 1, 0, 0, 0, 255));

    // Randomized segments of held lock level, random clear_fault and resets.
    apply_reset("pre_rand");
    for (int s = 0; s < 200; s++) begin
      len = $urandom_range(1, 40);
      val = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < len; k++) tick(val, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) apply_reset("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
